l2_port_arbiter: RTL and testbench

- Shares the single L1→L2 line-transfer port between the L1 instruction cache (requester I) and the L1 data cache (requester D).
- Each requester issues line refills (read) or dirty-line writebacks (write). The block grants round-robin, holds one outstanding L2 transaction at a time, routes the response back to the owner, and aborts hung transactions with a watchdog.
- Supplies the l2_wb_done / l2_refill_done completion events for the L1 miss FSMs.

---
 rtl/l2_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the L1->L2 line-transfer port between the I and D
// caches. Round-robin grant, one outstanding L2 transaction, watchdog abort.
module l2_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  // I-cache requester
  input  logic              l1i_req_valid,
  output logic              l1i_req_ready,
  input  logic              l1i_req_write,
  input  logic [ADDR_W-1:0] l1i_req_addr,
  input  logic [LINE_W-1:0] l1i_req_wdata,
  output logic              l1i_resp_valid,
  output logic [LINE_W-1:0] l1i_resp_rdata,
  output logic              l1i_resp_err,
  // D-cache requester
  input  logic              l1d_req_valid,
  output logic              l1d_req_ready,
  input  logic              l1d_req_write,
  input  logic [ADDR_W-1:0] l1d_req_addr,
  input  logic [LINE_W-1:0] l1d_req_wdata,
  output logic              l1d_resp_valid,
  output logic [LINE_W-1:0] l1d_resp_rdata,
  output logic              l1d_resp_err,
  // L2 side
  output logic              l2_req_valid,
  input  logic              l2_req_ready,
  output logic              l2_req_write,
  output logic [ADDR_W-1:0] l2_req_addr,
  output logic [LINE_W-1:0] l2_req_wdata,
  input  logic              l2_resp_valid,
  input  logic [LINE_W-1:0] l2_resp_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // Counter is wide enough to hold TIMEOUT; one extra bit on the increment
  // lets the compare be done without wrap-around.
  localparam int          CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW:0] TO_W = (CW + 1)'(TIMEOUT);

  state_t              state_q, state_d;
  logic                prio_d_q, prio_d_d;   // 1: D wins a tie
  logic                own_d_q, own_d_d;     // 1: D owns the transaction
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                gnt_any, gnt_d;
  logic [CW:0]         cnt_inc;
  logic                wd_hit;
  logic                in_resp;

  assign gnt_any = l1i_req_valid | l1d_req_valid;
  assign gnt_d   = l1d_req_valid & (~l1i_req_valid | prio_d_q);
  assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  assign wd_hit  = (TIMEOUT != 0) && (cnt_inc == TO_W);

  // State and captured-request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      prio_d_q <= 1'b1;
      own_d_q  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      prio_d_q <= prio_d_d;
      own_d_q  <= own_d_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state, grant and watchdog logic
  always_comb begin
    state_d       = state_q;
    prio_d_d      = prio_d_q;
    own_d_d       = own_d_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    l1i_req_ready = 1'b0;
    l1d_req_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        l1i_req_ready = l1i_req_valid & ~gnt_d;
        l1d_req_ready = gnt_d;
        if (gnt_any) begin
          own_d_d  = gnt_d;
          wr_d     = gnt_d ? l1d_req_write : l1i_req_write;
          addr_d   = gnt_d ? l1d_req_addr  : l1i_req_addr;
          wdata_d  = gnt_d ? l1d_req_wdata : l1i_req_wdata;
          prio_d_d = ~gnt_d;
          cnt_d    = '0;
          rdata_d  = '0;
          err_d    = 1'b0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_inc[CW-1:0];
        if (wd_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else if (l2_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc[CW-1:0];
        // A completion in the timeout cycle still counts as success.
        if (l2_resp_valid) begin
          rdata_d = wr_q ? '0 : l2_resp_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (wd_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Response routing: only the owner sees a pulse; data/err zero otherwise
  always_comb begin
    in_resp        = (state_q == S_RESP);
    l1i_resp_valid = in_resp & ~own_d_q;
    l1d_resp_valid = in_resp &  own_d_q;
    l1i_resp_rdata = l1i_resp_valid ? rdata_q : '0;
    l1d_resp_rdata = l1d_resp_valid ? rdata_q : '0;
    l1i_resp_err   = l1i_resp_valid & err_q;
    l1d_resp_err   = l1d_resp_valid & err_q;
  end

  assign l2_req_valid = (state_q == S_ISSUE);
  assign l2_req_write = wr_q;
  assign l2_req_addr  = addr_q;
  assign l2_req_wdata = wdata_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: vector table, hand-written reset/late-response
// sequences and randomized transactions against an arithmetic timing model.
module tb_l2_port_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 8;
  localparam int NEVER = 99;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          l1i_req_valid = 0, l1i_req_write = 0;
  logic [AW-1:0] l1i_req_addr = '0;
  logic [LW-1:0] l1i_req_wdata = '0;
  logic          l1i_req_ready, l1i_resp_valid, l1i_resp_err;
  logic [LW-1:0] l1i_resp_rdata;
  logic          l1d_req_valid = 0, l1d_req_write = 0;
  logic [AW-1:0] l1d_req_addr = '0;
  logic [LW-1:0] l1d_req_wdata = '0;
  logic          l1d_req_ready, l1d_resp_valid, l1d_resp_err;
  logic [LW-1:0] l1d_resp_rdata;
  logic          l2_req_valid, l2_req_write, busy;
  logic          l2_req_ready = 0, l2_resp_valid = 0;
  logic [AW-1:0] l2_req_addr;
  logic [LW-1:0] l2_req_wdata, l2_resp_rdata = '0;

  int errors = 0;
  int checks = 0;
  bit ptr_m;  // model: 1 = D wins a tie

  l2_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .l1i_req_valid(l1i_req_valid), .l1i_req_ready(l1i_req_ready),
    .l1i_req_write(l1i_req_write), .l1i_req_addr(l1i_req_addr),
    .l1i_req_wdata(l1i_req_wdata), .l1i_resp_valid(l1i_resp_valid),
    .l1i_resp_rdata(l1i_resp_rdata), .l1i_resp_err(l1i_resp_err),
    .l1d_req_valid(l1d_req_valid), .l1d_req_ready(l1d_req_ready),
    .l1d_req_write(l1d_req_write), .l1d_req_addr(l1d_req_addr),
    .l1d_req_wdata(l1d_req_wdata), .l1d_resp_valid(l1d_resp_valid),
    .l1d_resp_rdata(l1d_resp_rdata), .l1d_resp_err(l1d_resp_err),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
    .l2_req_write(l2_req_write), .l2_req_addr(l2_req_addr),
    .l2_req_wdata(l2_req_wdata), .l2_resp_valid(l2_resp_valid),
    .l2_resp_rdata(l2_resp_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    bit iv, dv, iw, dw;
    int rdy;      // L2 holds ready low for this many ISSUE cycles
    int rsp;      // WAIT cycles before completion (NEVER = no response)
    bit stray;    // extra l2_resp_valid pulses in IDLE and ISSUE
    bit exp_d;    // expected grant goes to D
    bit exp_err;
    int exp_lat;  // cycles from accept to resp_valid
  } vec_t;

  logic [13:0] outs;
  assign outs = {l1i_req_ready, l1i_resp_valid, l1i_resp_err, |l1i_resp_rdata,
                 l1d_req_ready, l1d_resp_valid, l1d_resp_err, |l1d_resp_rdata,
                 l2_req_valid, l2_req_write, |l2_req_addr, |l2_req_wdata,
                 busy, 1'b0};

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic chkw(input string n, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  // Reference model: grant rule plus the watchdog timeline as arithmetic.
  // Cycle k (1-based) counts ISSUE+WAIT cycles; the pulse lands one cycle
  // after the cycle in which the transaction ends.
  function automatic vec_t model(input vec_t v, inout bit ptr);
    int issue_cyc, done_cyc;
    vec_t r = v;
    r.exp_d = v.dv && (!v.iv || ptr);
    ptr = !r.exp_d;
    issue_cyc = v.rdy + 1;
    if (issue_cyc >= TO) begin
      r.exp_err = 1'b1; r.exp_lat = TO + 1;
    end else begin
      done_cyc = (v.rsp == NEVER) ? 1000 : issue_cyc + v.rsp + 1;
      r.exp_err = (done_cyc > TO);
      r.exp_lat = (done_cyc > TO) ? TO + 1 : done_cyc + 1;
    end
    return r;
  endfunction

  task automatic do_txn(input vec_t v, input int idx);
    logic [LW-1:0] pat, iwd, dwd, exp_rd, got_rd;
    logic [AW-1:0] ia, da;
    bit gi, gd, hs, seen, f_ok, nz_ok, got_d, got_err, own_w;
    int hs_k, lat;
    pat = (idx == 0) ? {32{8'hA5}} : {8{32'hC0DE_0000 ^ (idx * 32'h0101_0101)}};
    ia  = 32'h0000_3000 + idx * 64;
    da  = (idx == 0) ? 32'h0000_1000 : 32'h0000_2040 + idx * 64;
    iwd = {8{32'h1234_5678 + idx}};
    dwd = {8{32'h9ABC_DEF0 ^ idx}};
    @(negedge clk);
    l1i_req_valid = v.iv; l1i_req_write = v.iw; l1i_req_addr = ia; l1i_req_wdata = iwd;
    l1d_req_valid = v.dv; l1d_req_write = v.dw; l1d_req_addr = da; l1d_req_wdata = dwd;
    l2_resp_valid = v.stray; l2_resp_rdata = pat;
    #1;
    gi = l1i_req_ready; gd = l1d_req_ready;
    chk("grant_d", 32'(gd), 32'(v.exp_d));
    chk("grant_i", 32'(gi), 32'(!v.exp_d));
    @(negedge clk);
    l1i_req_valid = 0; l1d_req_valid = 0; l2_resp_valid = 0;
    hs = 0; hs_k = 0; seen = 0; f_ok = 1; nz_ok = 1; lat = 0;
    got_d = 0; got_err = 0; got_rd = '0;
    own_w = v.exp_d ? v.dw : v.iw;
    for (int k = 1; k <= 30 && !seen; k++) begin
      l2_req_ready  = !hs && (k == v.rdy + 1);
      l2_resp_valid = (hs && v.rsp != NEVER && k == hs_k + v.rsp + 1) ||
                      (v.stray && k == 1 && v.rdy >= 1);
      #1;
      if (k == 1) chk("busy_active", 32'(busy), 32'd1);
      if (l2_req_valid) begin
        if (l2_req_write !== own_w) f_ok = 0;
        if (l2_req_addr !== (v.exp_d ? da : ia)) f_ok = 0;
        if (l2_req_wdata !== (v.exp_d ? dwd : iwd)) f_ok = 0;
        if (l2_req_ready) begin hs = 1; hs_k = k; end
      end
      if (l1i_resp_valid || l1d_resp_valid) begin
        seen = 1; lat = k; got_d = l1d_resp_valid;
        got_err = got_d ? l1d_resp_err : l1i_resp_err;
        got_rd  = got_d ? l1d_resp_rdata : l1i_resp_rdata;
        if (got_d && (l1i_resp_valid || l1i_resp_err || |l1i_resp_rdata)) nz_ok = 0;
        if (!got_d && (l1d_resp_valid || l1d_resp_err || |l1d_resp_rdata)) nz_ok = 0;
      end
      @(negedge clk);
    end
    l2_req_ready = 0; l2_resp_valid = 0;
    exp_rd = (v.exp_err || own_w) ? '0 : pat;
    chk("resp_seen", 32'(seen), 32'd1);
    chk("resp_owner_d", 32'(got_d), 32'(v.exp_d));
    chk("resp_err", 32'(got_err), 32'(v.exp_err));
    chkw("resp_rdata", got_rd, exp_rd);
    chk("resp_latency", 32'(lat), 32'(v.exp_lat));
    chk("l2_req_fields_stable", 32'(f_ok), 32'd1);
    chk("non_owner_zero", 32'(nz_ok), 32'd1);
    #1;
    chk("post_pulse_single", 32'({l1i_resp_valid, l1d_resp_valid}), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    ptr_m = !v.exp_d;
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    //          iv dv iw dw rdy rsp    stray d  err lat
    tbl[0] = '{0, 1, 0, 0, 0, 0,     0,    1, 0, 3};  // D refill alone
    tbl[1] = '{1, 1, 0, 0, 0, 0,     0,    0, 0, 3};  // tie -> I
    tbl[2] = '{1, 1, 0, 0, 0, 0,     0,    1, 0, 3};  // tie -> D
    tbl[3] = '{1, 1, 0, 0, 0, 2,     0,    0, 0, 5};  // tie -> I
    tbl[4] = '{0, 1, 0, 1, 5, 0,     0,    1, 0, 8};  // D writeback, L2 stalls 5
    tbl[5] = '{1, 0, 0, 0, 0, NEVER, 0,    0, 1, 9};  // watchdog in WAIT
    tbl[6] = '{0, 1, 0, 0, 7, 0,     0,    1, 1, 9};  // watchdog in ISSUE
    tbl[7] = '{1, 0, 0, 0, 1, 5,     0,    0, 0, 9};  // completion ties timeout
    tbl[8] = '{1, 1, 1, 1, 0, 1,     0,    1, 0, 4};  // both writebacks
    tbl[9] = '{0, 1, 0, 0, 2, 0,     1,    1, 0, 5};  // stray responses ignored

    // Reset state
    #1;
    chk("reset_outputs", 32'(outs), 32'd0);
    #20 rst_n = 1'b1;

    // Tie after reset goes to D; then reset hits during WAIT
    @(negedge clk);
    l1i_req_valid = 1; l1d_req_valid = 1; #1;
    chk("first_tie_d", 32'({l1d_req_ready, l1i_req_ready}), 32'b10);
    @(negedge clk);
    l1i_req_valid = 0; l1d_req_valid = 0; l2_req_ready = 1;
    @(negedge clk);
    l2_req_ready = 0; #1;
    chk("in_wait_busy", 32'({busy, l2_req_valid}), 32'b10);
    #2 rst_n = 1'b0; #1;
    chk("async_reset_outputs", 32'(outs), 32'd0);
    @(negedge clk);
    l2_resp_valid = 1;  // response to the aborted request, ignored under reset
    @(negedge clk);
    l2_resp_valid = 0; rst_n = 1'b1;
    // Pointer was reset, so the tie goes to D again
    @(negedge clk);
    l1i_req_valid = 1; l1d_req_valid = 1; #1;
    chk("post_reset_tie_d", 32'({l1d_req_ready, l1i_req_ready}), 32'b10);
    @(negedge clk);
    l1i_req_valid = 0; l1d_req_valid = 0; l2_req_ready = 1;
    @(negedge clk);
    l2_req_ready = 0; l2_resp_valid = 1;
    @(negedge clk);
    l2_resp_valid = 0; #1;
    chk("post_reset_resp_d", 32'({l1d_resp_valid, l1i_resp_valid}), 32'b10);

    for (int i = 0; i < 10; i++) do_txn(tbl[i], i);

    // Watchdog abort followed by a late response in IDLE
    do_txn('{1, 0, 0, 0, 0, NEVER, 0, 0, 1, 9}, 10);
    @(negedge clk);
    l2_resp_valid = 1;
    @(negedge clk);
    l2_resp_valid = 0; #1;
    chk("late_resp_ignored", 32'({l1i_resp_valid, l1d_resp_valid, busy}), 32'd0);

    // Randomized transactions against the model
    for (int n = 0; n < 40; n++) begin
      rv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      rv.iv = 1'($urandom_range(0, 1));
      rv.dv = rv.iv ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.iw = 1'($urandom_range(0, 1));
      rv.dw = 1'($urandom_range(0, 1));
      rv.rdy = ($urandom_range(0, 9) == 0) ? 8 : int'($urandom_range(0, 4));
      rv.rsp = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 5));
      rv.stray = 1'($urandom_range(0, 3) == 0);
      rv = model(rv, ptr_m);
      do_txn(rv, 11 + n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
